// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      F_REQ   = 2'd0,
      F_HOLD  = 2'd1,
      F_DRAIN = 2'd2,
      F_ERROR = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP                  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC     = 32'h0000_0000;
   localparam int          DEFAULT_IMEM_TIMEOUT = 16;

   // One parked fetch result: the address+4 and the instruction word.
   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } hold_entry_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a fetched word while the IF/ID register stalls.
module fetch_hold_buf
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  hold_entry_t wdata,
   output hold_entry_t rdata
);

   hold_entry_t entry_reg;

   // Capture on load; clear wipes the entry so stale words never leak out.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         entry_reg <= '0;
      end else if (load) begin
         entry_reg <= wdata;
      end
   end

   assign rdata = entry_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, stall hold buffer, redirect drain,
// memory-timeout error trap.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
   parameter int          IMEM_TIMEOUT = DEFAULT_IMEM_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_plus4_out,
   output logic [31:0] instr_out,
   output logic        fetch_valid,
   output logic [1:0]  fetch_state,
   output logic [31:0] fetch_count,
   output logic [31:0] redirect_count
);

   localparam int                WAIT_W    = $clog2(IMEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IMEM_TIMEOUT - 1);

   fetch_state_t      state_reg;
   logic [31:0]       pc_reg;
   logic [31:0]       target_reg;
   logic [WAIT_W-1:0] wait_reg;
   logic [31:0]       pc_plus4_calc;
   logic              hold_load;
   logic              hold_clear;
   hold_entry_t       hold_wdata;
   hold_entry_t       hold_rdata;

   assign pc_plus4_calc = pc_reg + 32'd4;
   assign imem_req      = (state_reg == F_REQ) || (state_reg == F_DRAIN);
   assign imem_addr     = pc_reg;
   assign fetch_state   = state_reg;
   assign hold_wdata    = {pc_plus4_calc, imem_rdata};

   // Park the response when it arrives under stall; drop it once consumed or redirected.
   always_comb begin
      hold_load  = (state_reg == F_REQ) && imem_ready && stall && !redirect_valid;
      hold_clear = (state_reg == F_HOLD) && (redirect_valid || !stall);
   end

   fetch_hold_buf u_hold_buf (
      .clk   (clk),
      .reset (reset),
      .load  (hold_load),
      .clear (hold_clear),
      .wdata (hold_wdata),
      .rdata (hold_rdata)
   );

   // Fetch FSM with registered presentation outputs and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= F_REQ;
         pc_reg         <= RESET_PC;
         target_reg     <= RESET_PC;
         wait_reg       <= '0;
         pc_plus4_out   <= 32'h0;
         instr_out      <= NOP;
         fetch_valid    <= 1'b0;
         fetch_count    <= 32'h0;
         redirect_count <= 32'h0;
      end else if (state_reg == F_ERROR) begin
         // Sticky trap: present a bubble, ignore everything until reset.
         instr_out   <= NOP;
         fetch_valid <= 1'b0;
      end else if (redirect_valid) begin
         // Redirect wins over stall and kills whatever is in flight.
         redirect_count <= redirect_count + 32'd1;
         wait_reg       <= '0;
         instr_out      <= NOP;
         fetch_valid    <= 1'b0;
         if (redirect_pc[1:0] != 2'b00) begin
            state_reg <= F_ERROR;
         end else if (state_reg == F_HOLD || imem_ready) begin
            pc_reg    <= redirect_pc;
            state_reg <= F_REQ;
         end else begin
            // Request still outstanding: keep the address stable, drain it later.
            target_reg <= redirect_pc;
            state_reg  <= F_DRAIN;
         end
      end else begin
         case (state_reg)
            F_REQ: begin
               if (imem_ready) begin
                  wait_reg    <= '0;
                  pc_reg      <= pc_plus4_calc;
                  fetch_count <= fetch_count + 32'd1;
                  if (stall) begin
                     state_reg <= F_HOLD;
                  end else begin
                     pc_plus4_out <= pc_plus4_calc;
                     instr_out    <= imem_rdata;
                     fetch_valid  <= 1'b1;
                  end
               end else begin
                  if (wait_reg == WAIT_LAST) state_reg <= F_ERROR;
                  wait_reg <= wait_reg + WAIT_W'(1);
                  if (!stall) begin
                     instr_out   <= NOP;
                     fetch_valid <= 1'b0;
                  end
               end
            end
            F_HOLD: begin
               if (!stall) begin
                  pc_plus4_out <= hold_rdata.pc_plus4;
                  instr_out    <= hold_rdata.instr;
                  fetch_valid  <= 1'b1;
                  state_reg    <= F_REQ;
               end
            end
            F_DRAIN: begin
               if (imem_ready) begin
                  wait_reg  <= '0;
                  pc_reg    <= target_reg;
                  state_reg <= F_REQ;
               end else begin
                  if (wait_reg == WAIT_LAST) state_reg <= F_ERROR;
                  wait_reg <= wait_reg + WAIT_W'(1);
               end
               if (!stall) begin
                  instr_out   <= NOP;
                  fetch_valid <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected presentations.
module tb_fetch_unit;
   import fetch_pkg::*;

   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc_plus4_out;
   logic [31:0] instr_out;
   logic        fetch_valid;
   logic [1:0]  fetch_state;
   logic [31:0] fetch_count;
   logic [31:0] redirect_count;

   int   total  = 0;
   int   passed = 0;
   logic prev_stall = 1'b0;
   logic prev_reset = 1'b1;
   exp_t sb[$];

   fetch_unit #(.RESET_PC(32'h0), .IMEM_TIMEOUT(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .pc_plus4_out   (pc_plus4_out),
      .instr_out      (instr_out),
      .fetch_valid    (fetch_valid),
      .fetch_state    (fetch_state),
      .fetch_count    (fetch_count),
      .redirect_count (redirect_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Compare each fresh presentation against the scoreboard head.
   task automatic monitor();
      exp_t e;
      if (!prev_reset && !prev_stall && fetch_valid === 1'b1) begin
         total = total + 1;
         assert (sb.size() > 0) passed = passed + 1;
         else $error("FAIL sb_underflow: observed instr %h expected no presentation", instr_out);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("fetch: pc_plus4=%h instr=%h (expected %h %h)",
                     pc_plus4_out, instr_out, e.pc_plus4, e.instr);
            check("pres_pc_plus4", pc_plus4_out, e.pc_plus4);
            check("pres_instr", instr_out, e.instr);
         end
      end
      if (fetch_valid !== 1'b1) check("bubble_instr", instr_out, NOP);
   endtask

   task automatic cycle();
      prev_stall = stall;
      prev_reset = reset;
      @(posedge clk);
      #1;
      monitor();
   endtask

   initial begin
      logic [31:0] pc;
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_ready = 1'b0; imem_rdata = 32'h0;
      cycle(); cycle();
      check("rst_state", {30'h0, fetch_state}, 32'd0);
      check("rst_req", {31'h0, imem_req}, 32'd1);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_pc4", pc_plus4_out, 32'h0);
      check("rst_valid", {31'h0, fetch_valid}, 32'd0);
      check("rst_fcnt", fetch_count, 32'd0);
      check("rst_rcnt", redirect_count, 32'd0);
      reset = 1'b0;

      // Streaming fetch, word equals its address.
      pc = 32'h0;
      for (int i = 0; i < 3; i++) begin
         check("stream_addr", imem_addr, pc);
         imem_ready = 1'b1; imem_rdata = pc;
         sb.push_back('{pc_plus4: pc + 32'd4, instr: pc});
         cycle();
         pc = pc + 32'd4;
      end
      check("stream_fcnt", fetch_count, 32'd3);

      // Response under stall goes to the hold buffer.
      stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_0000;
      sb.push_back('{pc_plus4: pc + 32'd4, instr: 32'hDEAD_0000});
      cycle();
      pc = pc + 32'd4;
      imem_ready = 1'b0;
      check("hold_state", {30'h0, fetch_state}, 32'd1);
      check("hold_req", {31'h0, imem_req}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         cycle();
         check("hold_frozen_instr", instr_out, 32'h8);
         check("hold_frozen_pc4", pc_plus4_out, 32'hC);
      end
      stall = 1'b0;
      cycle();
      check("unhold_valid", {31'h0, fetch_valid}, 32'd1);
      check("unhold_state", {30'h0, fetch_state}, 32'd0);
      check("unhold_fcnt", fetch_count, 32'd4);
      cycle();
      check("bubble_pc4_kept", pc_plus4_out, 32'h10);

      // Redirect while the request is outstanding -> drain.
      cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      cycle();
      redirect_valid = 1'b0;
      check("drain_state", {30'h0, fetch_state}, 32'd2);
      check("drain_req", {31'h0, imem_req}, 32'd1);
      check("drain_addr_stable", imem_addr, pc);
      cycle();
      imem_ready = 1'b1; imem_rdata = 32'h0BAD_0BAD;
      cycle();
      imem_ready = 1'b0;
      pc = 32'h100;
      check("drain_done_state", {30'h0, fetch_state}, 32'd0);
      check("drain_next_addr", imem_addr, pc);
      check("drain_rcnt", redirect_count, 32'd1);
      check("drain_fcnt", fetch_count, 32'd4);

      // One fetch at the target, then redirect with stall and ready together.
      imem_ready = 1'b1; imem_rdata = 32'hA5A5_0100;
      sb.push_back('{pc_plus4: pc + 32'd4, instr: 32'hA5A5_0100});
      cycle();
      stall = 1'b1; imem_rdata = 32'h1234_5678;
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      cycle();
      redirect_valid = 1'b0; stall = 1'b0; imem_ready = 1'b0;
      pc = 32'h40;
      check("rs_valid", {31'h0, fetch_valid}, 32'd0);
      check("rs_addr", imem_addr, pc);
      check("rs_pc4_kept", pc_plus4_out, 32'h104);
      check("rs_fcnt", fetch_count, 32'd5);
      check("rs_rcnt", redirect_count, 32'd2);

      // Redirect out of F_HOLD discards the parked word.
      stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0000_0040;
      cycle();
      imem_ready = 1'b0;
      check("hold2_state", {30'h0, fetch_state}, 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      cycle();
      redirect_valid = 1'b0; stall = 1'b0;
      check("holdredir_state", {30'h0, fetch_state}, 32'd0);
      check("holdredir_addr", imem_addr, 32'h200);
      check("holdredir_fcnt", fetch_count, 32'd6);
      check("holdredir_rcnt", redirect_count, 32'd3);

      // Timeout: 15 idle cycles are tolerated, the 16th traps.
      for (int i = 0; i < 15; i++) cycle();
      check("pre_timeout_state", {30'h0, fetch_state}, 32'd0);
      cycle();
      check("timeout_state", {30'h0, fetch_state}, 32'd3);
      check("timeout_req", {31'h0, imem_req}, 32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h300;
      cycle();
      redirect_valid = 1'b0;
      check("err_redir_state", {30'h0, fetch_state}, 32'd3);
      check("err_redir_rcnt", redirect_count, 32'd3);
      check("err_valid", {31'h0, fetch_valid}, 32'd0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("rerst_state", {30'h0, fetch_state}, 32'd0);
      check("rerst_addr", imem_addr, 32'h0);
      check("rerst_fcnt", fetch_count, 32'd0);

      // Misaligned redirect traps immediately.
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      cycle();
      redirect_valid = 1'b0;
      check("misalign_state", {30'h0, fetch_state}, 32'd3);
      check("misalign_req", {31'h0, imem_req}, 32'd0);

      check("sb_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
